data_mem_ctrl: RTL and testbench

Parametrised, multi-cycle data-memory stage controller for the processor's memory stage. Owns a single-port word array and accepts one read or write per request. It holds the pipeline with `stall` for a configurable access latency and reports completion with a one-cycle `done` pulse. It also produces the stage's write-back value, selecting memory data on a completed read and the pass-through value otherwise, and flags misaligned or conflicting requests.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_array.sv | 23 ++
 rtl/data_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory stage controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_e;

    localparam int unsigned DEPTH_DEFAULT = 1024;
    localparam int unsigned IDX_W         = $clog2(DEPTH_DEFAULT);

    function automatic int unsigned idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word array; read data is registered every cycle, contents never reset.
module mem_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= din;
        end
        dout <= mem[idx];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage controller: accepts one read/write, holds the pipeline for LATENCY cycles,
// then pulses done and presents the write-back value.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              halt,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int unsigned IdxW = idx_w(DEPTH);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_dout;
    logic              req, bad, commit, mem_we;
    logic              unused_addr;

    assign unused_addr = ^addr[ADDR_W-1:IdxW+1];

    assign req    = (rd_en | wr_en) & ~halt;
    assign bad    = addr[0] | (rd_en & wr_en);
    assign commit = (state_q == BUSY) && (cnt_q == '0);
    // A reset landing on the commit edge cancels the in-flight write.
    assign mem_we = commit && (op_q == OP_WR) && rst;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IdxW)
    ) u_mem_array (
        .clk  (clk),
        .we   (mem_we),
        .idx  (idx_q),
        .din  (wdata_q),
        .dout (mem_dout)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        err_d     = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = wr_en ? OP_WR : OP_RD;
                        idx_d   = addr[IdxW:1];
                        wdata_d = wr_data;
                        cnt_d   = CntInit;
                        state_d = BUSY;
                        stall   = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                if (op_q == OP_RD) begin
                    rd_data_d = mem_dout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= OP_RD;
            idx_q     <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    // The array output register already holds the fresh word during DONE of a read.
    assign rd_data  = ((state_q == DONE) && (op_q == OP_RD)) ? mem_dout : rd_data_q;
    assign out_data = ((state_q == DONE) && (op_q == OP_RD)) ? rd_data : wr_data;
    assign err      = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl against an array-based reference model.
module tb_data_mem_ctrl;

    localparam int LAT = 2;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int DEP = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic          halt = 1'b0;
    logic [DW-1:0] out_data, rd_data;
    logic          stall, done, err;

    data_mem_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .DEPTH   (DEP),
        .LATENCY (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .halt     (halt),
        .out_data (out_data),
        .rd_data  (rd_data),
        .stall    (stall),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        bit            is_rd;
        bit            chk;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mdl [DEP];
    bit            known [DEP];
    logic [DW-1:0] last_rd = '0;
    bit            last_known = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int widx(input logic [AW-1:0] a);
        return (int'(a) / 2) % DEP;
    endfunction

    // Monitor: every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && (done || err)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 32'({done, err}), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("resp_kind", 32'({done, err}), mon_e.is_err ? 32'd1 : 32'd2);
                if (done && mon_e.is_rd && mon_e.chk) begin
                    chk("rd_out_data", 32'(out_data), 32'(mon_e.data));
                    chk("rd_data", 32'(rd_data), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output bit bad);
        exp_t e;
        int   w;
        bad      = a[0] || (rd && wr);
        w        = widx(a);
        e.is_err = bad;
        e.is_rd  = rd;
        e.chk    = 1'b0;
        e.data   = d;
        if (!bad) begin
            if (wr) begin
                mdl[w]   = d;
                known[w] = 1'b1;
            end else begin
                e.chk      = known[w];
                e.data     = mdl[w];
                last_rd    = mdl[w];
                last_known = known[w];
            end
        end
        sbq.push_back(e);
    endtask

    task automatic access(input bit rd, input bit wr, input bit hmid,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit bad;
        bit got;
        int nst;
        int cyc;
        @(posedge clk);
        #1;
        rd_en   = rd;
        wr_en   = wr;
        addr    = a;
        wr_data = d;
        if (!(rd || wr)) begin
            @(negedge clk);
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_pass", 32'(out_data), 32'(d));
            return;
        end
        issue(rd, wr, a, d, bad);
        if (bad) begin
            @(negedge clk);
            chk("bad_stall", 32'(stall), 32'd0);
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            wr_en = 1'b0;
            @(negedge clk);
            chk("bad_done", 32'(done), 32'd0);
            @(negedge clk);
            return;
        end
        nst = 0;
        got = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 4 * LAT + 10 && !got; c++) begin
            @(negedge clk);
            if (stall) nst++;
            if (done) begin
                got = 1'b1;
                cyc = c;
            end
            if (hmid && c == 2) halt = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, required done within %0d cycles", 4 * LAT + 10);
        end else begin
            chk("done_cycle", 32'(cyc), 32'(LAT + 2));
            if (!hmid) chk("stall_cycles", 32'(nst), 32'(LAT + 1));
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        chk("post_stall", 32'(stall), 32'd0);
        chk("post_pass", 32'(out_data), 32'(d));
        if (last_known) chk("rd_data_held", 32'(rd_data), 32'(last_rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            r_rd, r_wr;
        int            sel;
        logic [AW-1:0] ra;
        wr_data = 16'h5A5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_out_pass", 32'(out_data), 32'h5A5A);
        @(posedge clk);
        #1;
        rst = 1'b1;

        access(1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
        access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        access(1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000);
        access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        access(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1111);
        access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        access(1'b0, 1'b1, 1'b0, 16'h0802, 16'h1234);
        access(1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000);

        // Reset during BUSY of a write: the write must never land.
        access(1'b0, 1'b1, 1'b0, 16'h0004, 16'h5555);
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        addr    = 16'h0004;
        wr_data = 16'hAAAA;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 16'h0F0F;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
        chk("mid_rst_out", 32'(out_data), 32'h0F0F);
        last_rd    = '0;
        last_known = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        access(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000);

        // Halt raised mid-read; then requests under halt are ignored.
        access(1'b1, 1'b0, 1'b1, 16'h0802, 16'h0000);
        @(posedge clk);
        #1;
        rd_en = 1'b1;
        addr  = 16'h0010;
        repeat (5) begin
            @(negedge clk);
            chk("halt_stall", 32'(stall), 32'd0);
            chk("halt_done", 32'(done), 32'd0);
            chk("halt_err", 32'(err), 32'd0);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        halt  = 1'b0;

        for (int i = 0; i < 60; i++) begin
            sel  = int'($urandom_range(0, 9));
            r_rd = (sel <= 4) || (sel == 9);
            r_wr = (sel >= 5);
            ra   = AW'($urandom_range(0, 31) * 2) | AW'($urandom_range(0, 31) << 11);
            if ($urandom_range(0, 7) == 0) ra = ra | 16'h0001;
            access(r_rd, r_wr, 1'b0, ra, DW'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
